key_event_encoder: RTL and testbench
====================================

Name: key_event_encoder

Overview:
- Consumes a clean, debounced key level from the key debouncer and classifies each gesture as SHORT, LONG or DOUBLE press.
- Each classified gesture becomes one event code, delivered downstream over a one-entry valid/ready output slot.
- Sits between the key debouncer and control logic such as mode selection, LED or display control.

Parameters:
LONG_CYCLES, 32'd50_000*1000, press duration in cycles that qualifies as LONG (1 s at 50 MHz)
DCLICK_CYCLES, 32'd50_000*300, maximum release gap in cycles before a second press stops counting as DOUBLE (300 ms)
CNT_W, 32, width of the interval counter; must hold max(LONG_CYCLES, DCLICK_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key_level  in  1  debounced key, 1 = pressed
evt_valid  out  1  event slot holds an unconsumed event
evt_ready  in  1  consumer accepts the event this cycle
evt_code  out  2  2'b01 SHORT, 2'b10 LONG, 2'b11 DOUBLE, 2'b00 none
evt_overrun  out  1  one-cycle pulse when an event is dropped because the slot is full

Behaviour:
- Reset values: state IDLE, counter 0, evt_valid 0, evt_code 2'b00, evt_overrun 0. Reset mid-gesture aborts the gesture and clears any pending event; no event is emitted for the aborted gesture.
- Counter behaviour:
  - Counts +1 per cycle only in PRESS1 and GAP.
  - Clears to 0 on every state change and in every other state.
  - Never wraps, because each threshold forces a state exit.
- State machine (registered state; transition decided from the current-cycle key_level):
  - IDLE: key=1 -> PRESS1.
  - PRESS1:
    - key=0 -> GAP.
    - Else if counter >= LONG_CYCLES-1 -> emit LONG, go to WAIT_REL.
    - Release takes priority when both conditions hold in the same cycle.
  - GAP:
    - key=1 -> PRESS2.
    - Else if counter >= DCLICK_CYCLES-1 -> emit SHORT, go to IDLE.
    - Press takes priority when both conditions hold in the same cycle.
  - PRESS2: key=0 -> emit DOUBLE, go to IDLE. Hold duration is unbounded and a long second press is still DOUBLE.
  - WAIT_REL: key=0 -> IDLE. No event on release.
  - Unused encodings -> IDLE.
- Emission latency: the event appears on evt_valid/evt_code at the same clock edge that performs the emitting transition, i.e. one cycle after the deciding key sample.
- Output slot rules:
  - evt_valid && evt_ready consumes the event; evt_valid falls the next cycle unless a new emit occurs.
  - Emit with slot empty, or emit with evt_valid && evt_ready in the same cycle: load new code, evt_valid=1.
  - Emit with evt_valid && !evt_ready: new event dropped, slot unchanged, evt_overrun=1 for exactly one cycle.
  - evt_code is held stable while evt_valid=1 && !evt_ready.
  - evt_code returns to 2'b00 when the slot empties.
- At most one event per gesture. A maximal gesture is press-release-press-release.

Optional Feature:
KEY_EVT_SYNC_EN:
- Defined: key_level passes through a two-flop synchronizer (reset value 0) before the FSM. All decision latencies grow by 2 cycles. Use this when key_level originates in another clock domain.
- Undefined: key_level feeds the FSM directly; the input is already synchronous to clk.

Decomposition:
- Package key_evt_pkg holds:
  - event code constants EVT_NONE/EVT_SHORT/EVT_LONG/EVT_DOUBLE;
  - state encodings IDLE, PRESS1, GAP, PRESS2, WAIT_REL.
- One sub-module, key_evt_slot: the one-entry valid/ready output register. Inputs are load and code; it generates the overrun pulse.
- FSM and counter live in the top module.

Test Plan (LONG_CYCLES=10, DCLICK_CYCLES=5, sync macro undefined):
1. key=1 for 4 cycles, then 0 held, evt_ready=1 -> single SHORT (01) 5 cycles after the first released sample; evt_valid high 1 cycle; no further events.
2. key=1 held 15 cycles, then 0 -> LONG (10) at the 10th pressed cycle +1; no event on release; FSM back in IDLE.
3. key=1 x3, 0 x2, 1 x3, 0 -> exactly one DOUBLE (11) one cycle after the second release; no SHORT ever emitted.
4. evt_ready=0; SHORT gesture, then LONG gesture -> evt_code stays 01 with evt_valid=1; evt_overrun pulses 1 cycle at the LONG emit; raising evt_ready drains SHORT, then the slot is empty.
5. Reset asserted during PRESS1 (key still 1), deasserted, key released and held 0 -> no event; all outputs 0.
6. Boundary and back-to-back cases:
   - Release exactly at counter=9 in PRESS1 -> GAP, not LONG.
   - A second emit in the same cycle as evt_ready=1 on a full slot -> new code loaded, evt_valid stays 1, no overrun.

Source files
------------

// File: rtl/key_evt_pkg.sv
// -----------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key gesture encoder: event codes delivered
// downstream and the gesture state machine encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package key_evt_pkg;

  typedef logic [1:0] evt_code_t;

  localparam evt_code_t EVT_NONE   = 2'b00;
  localparam evt_code_t EVT_SHORT  = 2'b01;
  localparam evt_code_t EVT_LONG   = 2'b10;
  localparam evt_code_t EVT_DOUBLE = 2'b11;

  // Encodings 5..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    GAP      = 3'd2,
    PRESS2   = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

endpackage

// File: rtl/key_event_encoder_if.sv
// -----------------------------------------------------------------------------
// key_event_encoder_if
// Bundles the debounced key input and the one-entry event output slot.
//   key_level   : debounced key, 1 = pressed           (into encoder)
//   evt_ready   : consumer accepts the event this cycle (into encoder)
//   evt_valid   : slot holds an unconsumed event        (from encoder)
//   evt_code    : 01 SHORT, 10 LONG, 11 DOUBLE, 00 none (from encoder)
//   evt_overrun : one-cycle pulse, event dropped         (from encoder)
// Modports: master = encoder side, slave = key source / event consumer side.
// -----------------------------------------------------------------------------
interface key_event_encoder_if;
  import key_evt_pkg::*;

  logic      key_level;
  logic      evt_ready;
  logic      evt_valid;
  evt_code_t evt_code;
  logic      evt_overrun;

  modport master (
    input  key_level,
    input  evt_ready,
    output evt_valid,
    output evt_code,
    output evt_overrun
  );

  modport slave (
    output key_level,
    output evt_ready,
    input  evt_valid,
    input  evt_code,
    input  evt_overrun
  );

endinterface

// File: rtl/key_evt_slot.sv
// -----------------------------------------------------------------------------
// key_evt_slot
// One-entry valid/ready output register for classified key events.
// A load into an empty slot, or into a slot being consumed this cycle,
// replaces its contents. A load into a full, stalled slot is dropped and
// flagged with a one-cycle overrun pulse; the stored event is kept intact.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_load      : an event is emitted this cycle
//   i_code      : code of the emitted event
//   i_ready     : consumer accepts the held event this cycle
//   o_valid     : slot holds an unconsumed event
//   o_code      : held event code, EVT_NONE while empty
//   o_overrun   : one-cycle pulse when an emitted event is dropped
// -----------------------------------------------------------------------------
module key_evt_slot
  import key_evt_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_load,
  input  evt_code_t i_code,
  input  logic      i_ready,
  output logic      o_valid,
  output evt_code_t o_code,
  output logic      o_overrun
);

  logic      r_valid;
  evt_code_t r_code;
  logic      r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_code    <= EVT_NONE;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        // A consumer taking the old event frees room for the new one
        // within the same cycle.
        if (!r_valid || i_ready) begin
          r_valid <= 1'b1;
          r_code  <= i_code;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
        r_code  <= EVT_NONE;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_code    = r_code;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/key_event_encoder.sv
// -----------------------------------------------------------------------------
// key_event_encoder
// Classifies gestures on a debounced key as SHORT, LONG or DOUBLE press and
// delivers one event code per gesture through a one-entry valid/ready slot.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset (aborts any gesture in progress)
//   evt   : key_event_encoder_if.master (key_level, evt_ready in;
//           evt_valid, evt_code, evt_overrun out)
// Parameters:
//   CNT_W         : interval counter width, must hold both thresholds
//   LONG_CYCLES   : press length that qualifies as LONG
//   DCLICK_CYCLES : longest release gap still counted as a DOUBLE
// Optional feature (macro KEY_EVT_SYNC_EN):
//   defined   -> key_level passes a two-flop synchronizer (2 extra cycles)
//   undefined -> key_level feeds the state machine directly
// -----------------------------------------------------------------------------
module key_event_encoder
  import key_evt_pkg::*;
#(
  parameter int unsigned           CNT_W         = 32,
  parameter logic [CNT_W-1:0]      LONG_CYCLES   = 32'd50_000*1000,
  parameter logic [CNT_W-1:0]      DCLICK_CYCLES = 32'd50_000*300
) (
  input  logic                 clk,
  input  logic                 reset,
  key_event_encoder_if.master  evt
);

  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CYCLES - C_ONE;
  localparam logic [CNT_W-1:0] DCLICK_LAST = DCLICK_CYCLES - C_ONE;

  logic             w_key;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_longHit;
  logic             w_gapHit;
  logic             w_load;
  evt_code_t        w_code;

`ifdef KEY_EVT_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], evt.key_level};
    end
  end

  assign w_key = r_sync[1];
`else
  assign w_key = evt.key_level;
`endif

  assign w_longHit = (r_cnt >= LONG_LAST);
  assign w_gapHit  = (r_cnt >= DCLICK_LAST);

  // Emission decode: the slot registers the event on the same edge that
  // performs the emitting transition. Key changes win over threshold hits.
  always_comb begin
    w_load = 1'b0;
    w_code = EVT_NONE;
    case (r_state)
      PRESS1: begin
        if (w_key && w_longHit) begin
          w_load = 1'b1;
          w_code = EVT_LONG;
        end
      end
      GAP: begin
        if (!w_key && w_gapHit) begin
          w_load = 1'b1;
          w_code = EVT_SHORT;
        end
      end
      PRESS2: begin
        if (!w_key) begin
          w_load = 1'b1;
          w_code = EVT_DOUBLE;
        end
      end
      default: begin
      end
    endcase
  end

  // The counter only runs while timing a first press or a release gap and
  // restarts at zero on every state change, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        IDLE: begin
          if (w_key) begin
            r_state <= PRESS1;
          end
        end
        PRESS1: begin
          if (!w_key) begin
            r_state <= GAP;
          end else if (w_longHit) begin
            r_state <= WAIT_REL;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        GAP: begin
          if (w_key) begin
            r_state <= PRESS2;
          end else if (w_gapHit) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        PRESS2: begin
          if (!w_key) begin
            r_state <= IDLE;
          end
        end
        WAIT_REL: begin
          if (!w_key) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  key_evt_slot u_slot (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_code    (w_code),
    .i_ready   (evt.evt_ready),
    .o_valid   (evt.evt_valid),
    .o_code    (evt.evt_code),
    .o_overrun (evt.evt_overrun)
  );

endmodule

// File: tb/tb_key_event_encoder.sv
// -----------------------------------------------------------------------------
// tb_key_event_encoder
// Self-checking bench for key_event_encoder (LONG_CYCLES=10, DCLICK_CYCLES=5,
// KEY_EVT_SYNC_EN undefined). Gestures are described by their press/gap
// lengths; the expected event and its cycle are derived from those lengths,
// and a small slot model tracks what the consumer should observe.
// -----------------------------------------------------------------------------
module tb_key_event_encoder;

  localparam int LONG = 10;
  localparam int DCLK = 5;

  localparam logic [1:0] C_SHORT  = 2'b01;
  localparam logic [1:0] C_LONG   = 2'b10;
  localparam logic [1:0] C_DOUBLE = 2'b11;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  key_event_encoder_if evtIf ();

  key_event_encoder #(
    .CNT_W         (32),
    .LONG_CYCLES   (32'd10),
    .DCLICK_CYCLES (32'd5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .evt   (evtIf.master)
  );

  int compareCount  = 0;
  int mismatchCount = 0;

  // Key level and ready for each clock edge of a run, plus the event code
  // expected to be emitted at a given edge.
  bit         keySeq[$];
  bit         readySeq[$];
  logic [1:0] emitAt[int];

  logic       expValid;
  logic [1:0] expCode;
  logic       expOvr;

  task automatic checkOutput(input string tag, input logic [1:0] observed,
                             input logic [1:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", tag, observed,
               expected, $time);
    end
  endtask

  task automatic pushLevel(input bit lvl, input int n);
    for (int i = 0; i < n; i++) keySeq.push_back(lvl);
  endtask

  // kind 0: SHORT (p1 <= LONG, gap > DCLK), kind 1: LONG (p1 > LONG),
  // kind 2: DOUBLE (p1 <= LONG, gap g <= DCLK, any second press p2).
  task automatic addGesture(input int kind, input int p1, input int g,
                            input int p2, input int idle);
    int s;
    s = keySeq.size();
    case (kind)
      0: begin
        pushLevel(1'b1, p1);
        pushLevel(1'b0, DCLK + 1 + idle);
        emitAt[s + p1 + DCLK] = C_SHORT;
      end
      1: begin
        pushLevel(1'b1, p1);
        pushLevel(1'b0, idle);
        emitAt[s + LONG] = C_LONG;
      end
      default: begin
        pushLevel(1'b1, p1);
        pushLevel(1'b0, g);
        pushLevel(1'b1, p2);
        pushLevel(1'b0, idle);
        emitAt[s + p1 + g + p2] = C_DOUBLE;
      end
    endcase
  endtask

  // mode 0: always ready, 1: random, 2: never ready, 3: ready only on emits
  task automatic fillReady(input int mode);
    for (int i = readySeq.size(); i < keySeq.size(); i++) begin
      case (mode)
        0:       readySeq.push_back(1'b1);
        1:       readySeq.push_back(1'($urandom_range(0, 1)));
        2:       readySeq.push_back(1'b0);
        default: readySeq.push_back(emitAt.exists(i) ? 1'b1 : 1'b0);
      endcase
    end
  endtask

  task automatic addRandomGesture();
    int kind;
    kind = int'($urandom_range(0, 2));
    case (kind)
      0: addGesture(0, int'($urandom_range(1, LONG)), 0, 0,
                    int'($urandom_range(0, 3)));
      1: addGesture(1, int'($urandom_range(LONG + 1, LONG + 5)), 0, 0,
                    int'($urandom_range(1, 3)));
      default: addGesture(2, int'($urandom_range(1, LONG)),
                          int'($urandom_range(1, DCLK)),
                          int'($urandom_range(1, LONG + 6)), 0 + 1 +
                          int'($urandom_range(0, 2)));
    endcase
  endtask

  // Outputs seen at each falling edge reflect the previous rising edge.
  task automatic applyStimulus();
    for (int k = 0; k < keySeq.size(); k++) begin
      @(negedge clk);
      checkOutput("evt_valid", {1'b0, evtIf.evt_valid}, {1'b0, expValid});
      checkOutput("evt_code", evtIf.evt_code, expCode);
      checkOutput("evt_overrun", {1'b0, evtIf.evt_overrun}, {1'b0, expOvr});
      evtIf.key_level = keySeq[k];
      evtIf.evt_ready = readySeq[k];
      expOvr = 1'b0;
      if (emitAt.exists(k)) begin
        if (!expValid || readySeq[k]) begin
          expValid = 1'b1;
          expCode  = emitAt[k];
        end else begin
          expOvr = 1'b1;
        end
      end else if (expValid && readySeq[k]) begin
        expValid = 1'b0;
        expCode  = 2'b00;
      end
    end
    @(negedge clk);
    checkOutput("evt_valid_end", {1'b0, evtIf.evt_valid}, {1'b0, expValid});
    checkOutput("evt_code_end", evtIf.evt_code, expCode);
    checkOutput("evt_overrun_end", {1'b0, evtIf.evt_overrun}, {1'b0, expOvr});
    keySeq.delete();
    readySeq.delete();
    emitAt.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    evtIf.key_level = 1'b0;
    evtIf.evt_ready = 1'b0;
    expValid        = 1'b0;
    expCode         = 2'b00;
    expOvr          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {1'b0, evtIf.evt_valid}, 2'b00);
    checkOutput("rst_code", evtIf.evt_code, 2'b00);
    checkOutput("rst_overrun", {1'b0, evtIf.evt_overrun}, 2'b00);
    reset = 1'b0;

    pushLevel(1'b0, 3);               fillReady(0);
    addGesture(0, 4, 0, 0, 2);        fillReady(0);
    addGesture(1, 15, 0, 0, 3);       fillReady(0);
    addGesture(2, 3, 2, 3, 2);        fillReady(0);
    addGesture(0, 3, 0, 0, 0);        fillReady(2);
    addGesture(1, 12, 0, 0, 2);       fillReady(2);
    pushLevel(1'b0, 4);               fillReady(0);
    addGesture(0, LONG, 0, 0, 1);     fillReady(0);
    addGesture(1, LONG + 1, 0, 0, 1); fillReady(0);
    addGesture(2, 2, DCLK, 14, 2);    fillReady(0);
    addGesture(0, 2, 0, 0, 0);        fillReady(2);
    addGesture(2, 2, 1, 2, 3);        fillReady(3);
    pushLevel(1'b0, 3);               fillReady(0);
    for (int n = 0; n < 25; n++) begin
      addRandomGesture();
      fillReady(1);
    end
    pushLevel(1'b0, 8);               fillReady(0);
    applyStimulus();

    // Leave an event pending and a press in progress, then reset.
    addGesture(0, 2, 0, 0, 0);        fillReady(2);
    pushLevel(1'b1, 3);               fillReady(2);
    applyStimulus();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", {1'b0, evtIf.evt_valid}, 2'b00);
    checkOutput("midrst_code", evtIf.evt_code, 2'b00);
    checkOutput("midrst_overrun", {1'b0, evtIf.evt_overrun}, 2'b00);
    reset           = 1'b0;
    evtIf.key_level = 1'b0;
    evtIf.evt_ready = 1'b1;
    expValid        = 1'b0;
    expCode         = 2'b00;
    expOvr          = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("postrst_valid", {1'b0, evtIf.evt_valid}, 2'b00);
      checkOutput("postrst_code", evtIf.evt_code, 2'b00);
      checkOutput("postrst_overrun", {1'b0, evtIf.evt_overrun}, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount,
             mismatchCount);
    $finish;
  end

endmodule
